// File: rtl/nexus_nonce_fifo.sv
// nexus_nonce_fifo
//   Buffers winning nonces reported by the NexusHashTransform core and hands
//   them to the host-side reporter over a valid/ready handshake. Drops that
//   happen because the FIFO is full are made visible through a sticky
//   Overflow flag and a saturating DropCount. A Flush pulse (new work loaded)
//   discards every stale nonce.
//
//   Handshake: a nonce leaves the FIFO on a rising clk edge where
//   NonceOutValid && NonceOutReady. NonceOutValid is high exactly while the
//   FIFO is non-empty. NonceOut shows the head entry and stays stable while
//   Valid && !Ready. Ready may be held high indefinitely; when the FIFO is
//   empty it has no effect.
//
//   Optional build macro:
//     NONCE_DEDUP_EN - drop a push whose nonce equals the most recently
//                      accepted one, without counting it as a drop.
//
// Ports
//   clk            core clock, all logic on posedge
//   nHashRst       async active-low reset
//   NonceIn        nonce from hash core
//   NonceInValid   hash core GoodNonceFound, one nonce per high cycle
//   Flush          1-cycle pulse when new work is loaded
//   NonceOut       head-of-FIFO nonce (0 when empty)
//   NonceOutValid  FIFO not empty
//   NonceOutReady  consumer accepts head
//   Count          occupancy, 0..DEPTH
//   Overflow       sticky: a nonce was dropped because the FIFO was full
//   DropCount      nonces dropped on full, saturating
module nexus_nonce_fifo #(
    parameter int DEPTH         = 8,
    parameter int DROPCTR_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     nHashRst,
    input  logic [63:0]              NonceIn,
    input  logic                     NonceInValid,
    input  logic                     Flush,
    output logic [63:0]              NonceOut,
    output logic                     NonceOutValid,
    input  logic                     NonceOutReady,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    output logic [DROPCTR_WIDTH-1:0] DropCount
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]              wr_q, wr_d;
    logic [AW:0]              rd_q, rd_d;
    logic                     ovf_q, ovf_d;
    logic [DROPCTR_WIDTH-1:0] drop_q, drop_d;
    logic [63:0]              mem_q [DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic push_req;
    logic push;
    logic drop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && NonceOutReady;

`ifdef NONCE_DEDUP_EN
    logic [63:0] last_q, last_d;
    logic        last_valid_q, last_valid_d;
    logic        dup;

    assign dup      = last_valid_q && (NonceIn == last_q);
    assign push_req = NonceInValid && !dup;

    always_comb begin
        last_d       = last_q;
        last_valid_d = last_valid_q;
        if (Flush) begin
            last_valid_d = 1'b0;
        end else if (push) begin
            last_d       = NonceIn;
            last_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else begin
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
        end
    end
`else
    assign push_req = NonceInValid;
`endif

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is only lost when nothing leaves.
    assign push = push_req && (!full || pop);
    assign drop = push_req && full && !pop;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (Flush) begin
            // Flush beats any simultaneous push/pop; DropCount survives.
            wr_d  = '0;
            rd_d  = '0;
            ovf_d = 1'b0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    // Storage needs no reset: NonceOut is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push && !Flush) mem_q[wr_q[AW-1:0]] <= NonceIn;
    end

    assign NonceOut      = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign NonceOutValid = !empty;
    assign Count         = wr_q - rd_q;
    assign Overflow      = ovf_q;
    assign DropCount     = drop_q;

endmodule

// File: tb/tb_nexus_nonce_fifo.sv
module tb_nexus_nonce_fifo;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nHashRst;
    logic [63:0] NonceIn;
    logic        NonceInValid;
    logic        Flush;
    logic [63:0] NonceOut;
    logic        NonceOutValid;
    logic        NonceOutReady;
    logic [3:0]  Count;
    logic        Overflow;
    logic [15:0] DropCount;

    nexus_nonce_fifo #(.DEPTH(8), .DROPCTR_WIDTH(16)) dut (
        .clk           (clk),
        .nHashRst      (nHashRst),
        .NonceIn       (NonceIn),
        .NonceInValid  (NonceInValid),
        .Flush         (Flush),
        .NonceOut      (NonceOut),
        .NonceOutValid (NonceOutValid),
        .NonceOutReady (NonceOutReady),
        .Count         (Count),
        .Overflow      (Overflow),
        .DropCount     (DropCount)
    );

    // Small instance for drop-counter saturation.
    logic [63:0] s_in;
    logic        s_vin;
    logic        s_flush;
    logic [63:0] s_out;
    logic        s_valid;
    logic        s_rdy;
    logic [1:0]  s_cnt;
    logic        s_ovf;
    logic [1:0]  s_drop;

    nexus_nonce_fifo #(.DEPTH(2), .DROPCTR_WIDTH(2)) dut_s (
        .clk           (clk),
        .nHashRst      (nHashRst),
        .NonceIn       (s_in),
        .NonceInValid  (s_vin),
        .Flush         (s_flush),
        .NonceOut      (s_out),
        .NonceOutValid (s_valid),
        .NonceOutReady (s_rdy),
        .Count         (s_cnt),
        .Overflow      (s_ovf),
        .DropCount     (s_drop)
    );

    // ---------------- vectors ----------------
    typedef struct {
        logic        flush;
        logic        vin;
        logic [63:0] din;
        logic        rdy;
        logic        e_valid;
        logic [63:0] e_out;
        logic [3:0]  e_cnt;
        logic        e_ovf;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void add(input logic fl, input logic vi, input logic [63:0] d,
                                input logic r, input logic ev, input logic [63:0] eo,
                                input logic [3:0] ec, input logic eov, input logic [15:0] edr);
        vec_t v;
        v.flush = fl; v.vin = vi; v.din = d; v.rdy = r;
        v.e_valid = ev; v.e_out = eo; v.e_cnt = ec; v.e_ovf = eov; v.e_drop = edr;
        vecs.push_back(v);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [63:0] eo,
                           input logic [3:0] ec, input logic eov, input logic [15:0] edr);
        chk({tag, ".valid"}, {63'd0, NonceOutValid}, {63'd0, ev});
        chk({tag, ".nonce"}, NonceOut, eo);
        chk({tag, ".count"}, {60'd0, Count}, {60'd0, ec});
        chk({tag, ".overflow"}, {63'd0, Overflow}, {63'd0, eov});
        chk({tag, ".dropcount"}, {48'd0, DropCount}, {48'd0, edr});
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic fl, input logic vi, input logic [63:0] d, input logic r);
        Flush = fl; NonceInValid = vi; NonceIn = d; NonceOutReady = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] n;
        logic [63:0] nonce1;
        nonce1 = 64'h00000001FCAFC044;

        // Test 1: single push then pop
        add(0, 1, nonce1, 0, 1, nonce1, 1, 0, 0);
        add(0, 0, 0,      1, 0, 0,      0, 0, 0);
        // Test 2: fill 1..8, then drop 9
        for (int i = 1; i <= 8; i++) add(0, 1, 64'(i), 0, 1, 64'd1, 4'(i), 0, 0);
        add(0, 1, 64'd9, 0, 1, 64'd1, 8, 1, 1);
        // Test 3: push A and pop while full, then drain 2..8, A
        add(0, 1, 64'hA, 1, 1, 64'd2, 8, 1, 1);
        for (int k = 1; k <= 6; k++) add(0, 0, 0, 1, 1, 64'(k + 2), 4'(8 - k), 1, 1);
        add(0, 0, 0, 1, 1, 64'hA, 1, 1, 1);
        add(0, 0, 0, 1, 0, 0,     0, 1, 1);
        // Test 4: load 3, flush with simultaneous push B and ready
        add(0, 1, 64'hC1, 0, 1, 64'hC1, 1, 1, 1);
        add(0, 1, 64'hC2, 0, 1, 64'hC1, 2, 1, 1);
        add(0, 1, 64'hC3, 0, 1, 64'hC1, 3, 1, 1);
        add(1, 1, 64'hB,  1, 0, 0,      0, 0, 1);
        add(0, 0, 0,      1, 0, 0,      0, 0, 1);
        // Test 5: 12 nonces streamed with Ready held high
        for (int i = 0; i < 12; i++) add(0, 1, 64'h100 + 64'(i), 1, 1, 64'h100 + 64'(i), 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1);
        // Test 6: back-to-back duplicate nonce
        add(0, 1, 64'h5, 0, 1, 64'h5, 1, 0, 1);
`ifdef NONCE_DEDUP_EN
        add(0, 1, 64'h5, 0, 1, 64'h5, 1, 0, 1);
        add(1, 0, 0,     0, 0, 0,     0, 0, 1);
        add(0, 1, 64'h5, 0, 1, 64'h5, 1, 0, 1);
        add(0, 0, 0,     1, 0, 0,     0, 0, 1);
`else
        add(0, 1, 64'h5, 0, 1, 64'h5, 2, 0, 1);
        add(0, 0, 0,     1, 1, 64'h5, 1, 0, 1);
        add(0, 0, 0,     1, 0, 0,     0, 0, 1);
`endif

        // Reset
        nHashRst = 1'b0;
        NonceIn = '0; NonceInValid = 1'b0; Flush = 1'b0; NonceOutReady = 1'b0;
        s_in = '0; s_vin = 1'b0; s_flush = 1'b0; s_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        nHashRst = 1'b1;

        // Table
        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].vin, vecs[i].din, vecs[i].rdy);
            chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_out,
                    vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_drop);
        end

        // Drop-counter saturation on the small instance
        for (int i = 0; i < 7; i++) begin
            s_vin = 1'b1; s_in = 64'(i + 1);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.count", i), {62'd0, s_cnt}, (i == 0) ? 64'd1 : 64'd2);
            chk($sformatf("sat%0d.drop", i), {62'd0, s_drop},
                (i < 2) ? 64'd0 : ((i - 1 > 3) ? 64'd3 : 64'(i - 1)));
            chk($sformatf("sat%0d.ovf", i), {63'd0, s_ovf}, (i < 2) ? 64'd0 : 64'd1);
        end
        s_vin = 1'b0;
        chk("sat.head", s_out, 64'd1);

        // Asynchronous reset in mid-operation
        drive(0, 1, 64'hDEAD, 0);
        drive(0, 1, 64'hBEEF, 0);
        chk_all("pre_rst", 1, 64'hDEAD, 2, 0, 1);
        NonceInValid = 1'b1; NonceIn = 64'hF00D;
        #2;
        nHashRst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        chk("async_rst.small_count", {62'd0, s_cnt}, 64'd0);
        NonceInValid = 1'b0;
        @(negedge clk);
        nHashRst = 1'b1;
        n = 64'h1234;
        drive(0, 1, n, 0);
        chk_all("post_rst", 1, n, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
